// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and steers the IF/ID and ID/EX
// latches through load-use stalls, branch/jump redirects and halt.
//
// state | meaning
// RUN   | normal fetch; PC follows next_pc unless stalled or halting
// FLUSH | wrong-path instructions still returning from imem are squashed
// HALT  | halt instruction has passed decode; PC frozen until reset
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter int          IMEM_LATENCY = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      next_pc,
  input  logic             branched_jumped,
  input  logic             stall,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             fd_write_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Number of extra squash cycles after the one spent in the redirect cycle
  // itself; imem latency is 1..3, so two bits are enough.
  localparam logic [1:0] FLUSH_RELOAD = 2'(IMEM_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [1:0]  flush_cnt;
  logic [1:0]  flush_cnt_nxt;
  logic        stall_event;
  logic        redirect_event;

  // State, PC and squash counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state, next-PC and latch controls from the current state and inputs.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    flush_cnt_nxt  = flush_cnt;
    fetch_valid    = 1'b1;
    fd_write_en    = 1'b1;
    fd_flush       = 1'b0;
    dx_flush       = 1'b0;
    halted         = 1'b0;
    stall_event    = 1'b0;
    redirect_event = 1'b0;

    case (state)
      RUN: begin
        if (branched_jumped) begin
          // stall/halt_req come from younger wrong-path instructions here.
          pc_nxt         = next_pc;
          fd_flush       = 1'b1;
          dx_flush       = 1'b1;
          flush_cnt_nxt  = FLUSH_RELOAD;
          state_nxt      = FLUSH;
          redirect_event = 1'b1;
        end else if (stall) begin
          fd_write_en = 1'b0;
          dx_flush    = 1'b1;
          stall_event = 1'b1;
        end else if (halt_req) begin
          // The halt itself moves on to execute; nothing behind it does.
          fd_flush  = 1'b1;
          state_nxt = HALT;
        end else begin
          pc_nxt = next_pc;
        end
      end

      FLUSH: begin
        fd_flush = 1'b1;
        pc_nxt   = next_pc;
        if (branched_jumped) begin
          dx_flush       = 1'b1;
          flush_cnt_nxt  = FLUSH_RELOAD;
          redirect_event = 1'b1;
        end else if (flush_cnt == 2'd0) begin
          state_nxt = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
        end
      end

      HALT: begin
        fetch_valid = 1'b0;
        fd_flush    = 1'b1;
        halted      = 1'b1;
      end

      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Saturating debug event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (stall_event && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (redirect_event && (redirect_count != {CNT_W{1'b1}}))
        redirect_count <= redirect_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instance A uses default parameters,
// instance B uses IMEM_LATENCY=2 and a 4-bit counter for the saturation test.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        a_bj, a_st, a_hr;
  logic [31:0] a_npc, a_pc;
  logic        a_fv, a_we, a_ff, a_df, a_h;
  logic [15:0] a_sc, a_rc;

  logic        b_bj, b_st, b_hr;
  logic [31:0] b_npc, b_pc;
  logic        b_fv, b_we, b_ff, b_df, b_h;
  logic [3:0]  b_sc, b_rc;

  fetch_sequencer #(.RESET_PC(32'd0), .IMEM_LATENCY(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .next_pc(a_npc), .branched_jumped(a_bj),
    .stall(a_st), .halt_req(a_hr), .pc(a_pc), .fetch_valid(a_fv),
    .fd_write_en(a_we), .fd_flush(a_ff), .dx_flush(a_df), .halted(a_h),
    .stall_count(a_sc), .redirect_count(a_rc)
  );

  fetch_sequencer #(.RESET_PC(32'd0), .IMEM_LATENCY(2), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .next_pc(b_npc), .branched_jumped(b_bj),
    .stall(b_st), .halt_req(b_hr), .pc(b_pc), .fetch_valid(b_fv),
    .fd_write_en(b_we), .fd_flush(b_ff), .dx_flush(b_df), .halted(b_h),
    .stall_count(b_sc), .redirect_count(b_rc)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          sel;
    string       tag;
    logic [31:0] pc;
    logic [4:0]  flags;   // {fetch_valid, fd_write_en, fd_flush, dx_flush, halted}
  } exp_t;

  exp_t sb[$];

  localparam logic [4:0] F_RUN   = 5'b11000;
  localparam logic [4:0] F_STALL = 5'b10010;
  localparam logic [4:0] F_REDIR = 5'b11110;
  localparam logic [4:0] F_FLUSH = 5'b11100;
  localparam logic [4:0] F_HREQ  = 5'b11100;
  localparam logic [4:0] F_HALT  = 5'b01101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cursor is always at a negedge: drive, queue expectation, check, advance.
  task automatic step(input bit sel, input string tag, input logic bj, input logic st,
                      input logic hr, input logic [31:0] npc,
                      input logic [31:0] epc, input logic [4:0] eflags);
    exp_t e;
    if (sel == 1'b0) begin
      a_bj = bj; a_st = st; a_hr = hr; a_npc = npc;
    end else begin
      b_bj = bj; b_st = st; b_hr = hr; b_npc = npc;
    end
    e.sel = sel; e.tag = tag; e.pc = epc; e.flags = eflags;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    if (e.sel == 1'b0) begin
      chk({e.tag, "_pc"}, a_pc, e.pc);
      chk({e.tag, "_flags"}, 32'({a_fv, a_we, a_ff, a_df, a_h}), 32'(e.flags));
    end else begin
      chk({e.tag, "_pc"}, b_pc, e.pc);
      chk({e.tag, "_flags"}, 32'({b_fv, b_we, b_ff, b_df, b_h}), 32'(e.flags));
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_bj = 0; a_st = 0; a_hr = 0; a_npc = 32'd0;
    b_bj = 0; b_st = 0; b_hr = 0; b_npc = 32'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_bj = 0; a_st = 0; a_hr = 0; a_npc = 32'd0;
    b_bj = 0; b_st = 0; b_hr = 0; b_npc = 32'd0;
    @(negedge clock);
    do_reset();
    chk("a_reset_stall_cnt", 32'(a_sc), 32'd0);
    chk("a_reset_redir_cnt", 32'(a_rc), 32'd0);

    // Free run 0..4
    for (int i = 0; i < 5; i++)
      step(0, "a_run", 0, 0, 0, 32'(i + 1), 32'(i), F_RUN);

    // Load-use stall at pc=5 for two cycles
    step(0, "a_stall1", 0, 1, 0, 32'd6, 32'd5, F_STALL);
    step(0, "a_stall2", 0, 1, 0, 32'd6, 32'd5, F_STALL);
    step(0, "a_post_stall", 0, 0, 0, 32'd6, 32'd5, F_RUN);
    chk("a_stall_cnt_2", 32'(a_sc), 32'd2);
    step(0, "a_run6", 0, 0, 0, 32'd7, 32'd6, F_RUN);
    step(0, "a_run7", 0, 0, 0, 32'd8, 32'd7, F_RUN);

    // Redirect wins over a simultaneous stall
    step(0, "a_redir", 1, 1, 0, 32'h40, 32'd8, F_REDIR);
    step(0, "a_flush", 0, 0, 0, 32'h41, 32'h40, F_FLUSH);
    step(0, "a_target", 0, 0, 0, 32'h42, 32'h41, F_RUN);
    chk("a_redir_cnt_1", 32'(a_rc), 32'd1);
    chk("a_stall_cnt_kept", 32'(a_sc), 32'd2);

    // Halt at pc=0x10, then inputs ignored
    step(0, "a_run42", 0, 0, 0, 32'h10, 32'h42, F_RUN);
    step(0, "a_halt_req", 0, 0, 1, 32'h11, 32'h10, F_HREQ);
    for (int i = 0; i < 10; i++)
      step(0, "a_halted", logic'(i % 2), logic'(i % 3 == 0), 1'b1, 32'h99, 32'h10, F_HALT);
    chk("a_halt_redir_cnt", 32'(a_rc), 32'd1);
    chk("a_halt_stall_cnt", 32'(a_sc), 32'd2);
    do_reset();
    step(0, "a_after_halt_reset", 0, 0, 0, 32'd1, 32'd0, F_RUN);
    chk("a_rst_stall_cnt", 32'(a_sc), 32'd0);
    chk("a_rst_redir_cnt", 32'(a_rc), 32'd0);

    // Instance B: latency 2, back-to-back redirect reloads the squash window
    do_reset();
    step(1, "b_run0", 0, 0, 0, 32'd1, 32'd0, F_RUN);
    step(1, "b_redir1", 1, 0, 0, 32'h100, 32'd1, F_REDIR);
    step(1, "b_redir2", 1, 0, 0, 32'h200, 32'h100, F_REDIR);
    step(1, "b_flush_a", 0, 0, 0, 32'h201, 32'h200, F_FLUSH);
    step(1, "b_flush_b", 0, 0, 0, 32'h202, 32'h201, F_FLUSH);
    step(1, "b_run202", 0, 0, 0, 32'h203, 32'h202, F_RUN);
    chk("b_redir_cnt_2", 32'(b_rc), 32'd2);

    // Stall 2^4+5 cycles: counter saturates at 15
    for (int i = 0; i < 21; i++) begin
      step(1, "b_long_stall", 0, 1, 0, 32'h204, 32'h203, F_STALL);
      if (i == 14) chk("b_stall_cnt_15", 32'(b_sc), 32'd15);
    end
    chk("b_stall_cnt_sat", 32'(b_sc), 32'd15);
    step(1, "b_resume", 0, 0, 0, 32'h204, 32'h203, F_RUN);

    // Reset in the middle of FLUSH
    step(1, "b_redir3", 1, 0, 0, 32'h300, 32'h204, F_REDIR);
    do_reset();
    step(1, "b_reset_in_flush", 0, 0, 0, 32'd1, 32'd0, F_RUN);
    chk("b_rst_redir_cnt", 32'(b_rc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
